// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: requester-side request/response bundle of alu_share_arbiter.
interface alu_share_arbiter_if #(
   parameter int NUM_REQ = 2,
   parameter int IDW     = 3
);
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [32*NUM_REQ-1:0] req_a;
   logic [32*NUM_REQ-1:0] req_b;
   logic [14*NUM_REQ-1:0] req_sig;
   logic                  resp_valid;
   logic [IDW-1:0]        resp_id;
   logic [31:0]           resp_result;
   logic [1:0]            resp_flags;
   logic                  busy;
   modport master (
      output req_valid, req_a, req_b, req_sig,
      input  req_ready, resp_valid, resp_id, resp_result, resp_flags, busy
   );
   modport slave (
      input  req_valid, req_a, req_b, req_sig,
      output req_ready, resp_valid, resp_id, resp_result, resp_flags, busy
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU, one op in flight.
// Optional ALU_DIV0_GUARD_EN: div/mod by zero bypasses the ALU with a fixed 1-cycle result.
module alu_share_arbiter #(
   parameter int NUM_REQ   = 2,
   parameter int MULTI_LAT = 4,
   parameter int IDW       = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   alu_share_arbiter_if.slave    bus,
   output logic [31:0]           alu_a,
   output logic [31:0]           alu_b,
   output logic [13:0]           alu_signals,
   input  logic [31:0]           alu_result,
   input  logic [1:0]            alu_flags
);
   localparam int CW = MULTI_LAT > 1 ? $clog2(MULTI_LAT) : 1;
   typedef enum logic {IDLE, EXEC} state_t;
   state_t         state_q, state_d;
   logic [IDW-1:0] rr_ptr_q, rr_ptr_d, gid_q, gid_d, resp_id_q, resp_id_d;
   logic [IDW-1:0] gnt, gnt_hi, gnt_lo;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [31:0]    alu_a_q, alu_a_d, alu_b_q, alu_b_d, ovr_res_q, ovr_res_d;
   logic [31:0]    resp_result_q, resp_result_d, a_sel, b_sel;
   logic [13:0]    alu_sig_q, alu_sig_d, sig_sel;
   logic [1:0]     resp_flags_q, resp_flags_d;
   logic           ovr_q, ovr_d, resp_valid_q, resp_valid_d;
   logic           any_hi, any_lo, div0;
   logic [4:0]     op;
   // Lowest valid index at or above rr_ptr wins; otherwise wrap to the lowest valid index.
   always_comb begin
      any_hi = 1'b0;
      any_lo = 1'b0;
      gnt_hi = '0;
      gnt_lo = '0;
      a_sel = '0;
      b_sel = '0;
      sig_sel = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (bus.req_valid[i] && IDW'(i) >= rr_ptr_q) begin
            gnt_hi = IDW'(i);
            any_hi = 1'b1;
         end
         if (bus.req_valid[i]) begin
            gnt_lo = IDW'(i);
            any_lo = 1'b1;
         end
      end
      gnt = any_hi ? gnt_hi : gnt_lo;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (IDW'(i) == gnt) begin
            a_sel = bus.req_a[32*i +: 32];
            b_sel = bus.req_b[32*i +: 32];
            sig_sel = bus.req_sig[14*i +: 14];
         end
      end
   end
   assign op = sig_sel[13:9];
   assign bus.req_ready = (state_q == IDLE && any_lo && !reset) ? NUM_REQ'(1) << gnt : '0;
`ifdef ALU_DIV0_GUARD_EN
   assign div0 = (op == 5'b00011 || op == 5'b00100) && b_sel == '0;
`else
   assign div0 = 1'b0;
`endif
   always_comb begin
      state_d = state_q;
      rr_ptr_d = rr_ptr_q;
      gid_d = gid_q;
      cnt_d = cnt_q;
      alu_a_d = alu_a_q;
      alu_b_d = alu_b_q;
      alu_sig_d = alu_sig_q;
      ovr_d = ovr_q;
      ovr_res_d = ovr_res_q;
      resp_valid_d = 1'b0;
      resp_id_d = resp_id_q;
      resp_result_d = resp_result_q;
      resp_flags_d = resp_flags_q;
      if (state_q == IDLE && any_lo) begin
         state_d = EXEC;
         rr_ptr_d = gnt == IDW'(NUM_REQ - 1) ? '0 : gnt + 1'b1;
         gid_d = gnt;
         alu_a_d = a_sel;
         alu_b_d = b_sel;
         alu_sig_d = sig_sel;
         cnt_d = (op inside {5'b00010, 5'b00011, 5'b00100}) && !div0 ? CW'(MULTI_LAT - 1) : '0;
         // Undefined opcodes and guarded div0 return a fixed value instead of the ALU output.
         ovr_d = op == 5'b01101 || op[4] || div0;
         ovr_res_d = div0 ? (op[0] ? 32'hFFFF_FFFF : a_sel) : '0;
      end else if (state_q == EXEC) begin
         cnt_d = cnt_q != '0 ? cnt_q - 1'b1 : cnt_q;
         state_d = cnt_q != '0 ? EXEC : IDLE;
         resp_valid_d = cnt_q == '0;
         resp_id_d = cnt_q == '0 ? gid_q : resp_id_q;
         resp_result_d = cnt_q == '0 ? (ovr_q ? ovr_res_q : alu_result) : resp_result_q;
         resp_flags_d = cnt_q == '0 ? (ovr_q ? 2'b00 : alu_flags) : resp_flags_q;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         rr_ptr_q <= '0;
         gid_q <= '0;
         cnt_q <= '0;
         alu_a_q <= '0;
         alu_b_q <= '0;
         alu_sig_q <= '0;
         ovr_q <= 1'b0;
         ovr_res_q <= '0;
         resp_valid_q <= 1'b0;
         resp_id_q <= '0;
         resp_result_q <= '0;
         resp_flags_q <= '0;
      end else begin
         state_q <= state_d;
         rr_ptr_q <= rr_ptr_d;
         gid_q <= gid_d;
         cnt_q <= cnt_d;
         alu_a_q <= alu_a_d;
         alu_b_q <= alu_b_d;
         alu_sig_q <= alu_sig_d;
         ovr_q <= ovr_d;
         ovr_res_q <= ovr_res_d;
         resp_valid_q <= resp_valid_d;
         resp_id_q <= resp_id_d;
         resp_result_q <= resp_result_d;
         resp_flags_q <= resp_flags_d;
      end
   end
   assign alu_a = alu_a_q;
   assign alu_b = alu_b_q;
   assign alu_signals = alu_sig_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_id = resp_id_q;
   assign bus.resp_result = resp_result_q;
   assign bus.resp_flags = resp_flags_q;
   assign bus.busy = state_q != IDLE;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed plus randomized checks of alu_share_arbiter against a cycle-level model.
module tb_alu_share_arbiter;
   localparam int N = 3, ML = 4, IDW = 3;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   alu_share_arbiter_if #(.NUM_REQ(N), .IDW(IDW)) bus ();
   logic [31:0] alu_a, alu_b, alu_result;
   logic [13:0] alu_signals;
   logic [1:0]  alu_flags;
   alu_share_arbiter #(.NUM_REQ(N), .MULTI_LAT(ML), .IDW(IDW)) dut (
      .clk(clk), .reset(rst), .bus(bus),
      .alu_a(alu_a), .alu_b(alu_b), .alu_signals(alu_signals),
      .alu_result(alu_result), .alu_flags(alu_flags)
   );
   // Stand-in ALU: add, sub, mul, div, mod, cmp; anything else returns a scrambled value.
   function automatic logic [33:0] alu_fn(logic [4:0] op, logic [31:0] a, logic [31:0] b);
      case (op)
         5'd0: return {2'b00, a + b};
         5'd1: return {2'b00, a - b};
         5'd2: return {2'b00, a * b};
         5'd3: return {2'b00, b == 0 ? 32'hDEAD_BEEF : a / b};
         5'd4: return {2'b00, b == 0 ? 32'hBAD0_0BAD : a % b};
         5'd5: return {a > b, a == b, 32'h0};
         default: return {2'b11, a ^ b ^ 32'h5A5A_0001};
      endcase
   endfunction
   assign {alu_flags, alu_result} = alu_fn(alu_signals[13:9], alu_a, alu_b);
   int checks = 0, errors = 0, pcyc = 0;
   always @(posedge clk) pcyc++;
   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic exp_of(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [33:0] r, output int lat);
      logic guard;
      guard = 1'b0;
`ifdef ALU_DIV0_GUARD_EN
      guard = (op == 5'd3 || op == 5'd4) && b == 0;
`endif
      if (op == 5'd13 || op >= 5'd16) begin
         r = '0;
         lat = 2;
      end else if (guard) begin
         r = {2'b00, op == 5'd3 ? 32'hFFFF_FFFF : a};
         lat = 2;
      end else begin
         r = alu_fn(op, a, b);
         lat = (op >= 5'd2 && op <= 5'd4) ? 1 + ML : 2;
      end
   endtask
   // Reference model: one pending op with a due cycle, round-robin pointer, held outputs.
   bit started = 0, pend = 0, rv;
   int due, m_rr = 0, g, j, lat;
   logic [31:0] e_a = 0, e_b = 0;
   logic [13:0] e_sig = 0;
   logic [IDW-1:0] e_id = 0, p_id = 0;
   logic [33:0] e_resp = 0, p_resp = 0;
   logic [N-1:0] exp_ready;
   always @(negedge clk) begin
      if (!started) begin
         started = rst;
      end else begin
         chk("busy", bus.busy, pend && pcyc < due);
         rv = pend && pcyc == due;
         chk("resp_valid", bus.resp_valid, rv);
         if (rv) begin
            e_id = p_id;
            e_resp = p_resp;
            pend = 0;
         end
         chk("resp_id", bus.resp_id, e_id);
         chk("resp_data", {bus.resp_flags, bus.resp_result}, e_resp);
         chk("alu_a", alu_a, e_a);
         chk("alu_b", alu_b, e_b);
         chk("alu_sig", alu_signals, e_sig);
         exp_ready = '0;
         if (!pend && !rst) begin
            for (int k = 0; k < N; k++) begin
               j = (m_rr + k) % N;
               if (exp_ready == '0 && bus.req_valid[j]) begin
                  exp_ready[j] = 1'b1;
                  g = j;
               end
            end
         end
         chk("req_ready", bus.req_ready, exp_ready);
         if (exp_ready != '0) begin
            pend = 1;
            e_a = bus.req_a[32*g +: 32];
            e_b = bus.req_b[32*g +: 32];
            e_sig = bus.req_sig[14*g +: 14];
            exp_of(e_sig[13:9], e_a, e_b, p_resp, lat);
            due = pcyc + lat;
            p_id = IDW'(g);
            m_rr = (g + 1) % N;
         end
         if (rst) begin
            pend = 0;
            m_rr = 0;
            e_a = 0;
            e_b = 0;
            e_sig = 0;
            e_id = 0;
            e_resp = 0;
         end
      end
   end
   task automatic set_req(int i, logic [4:0] op, logic [31:0] a, logic [31:0] b);
      bus.req_valid[i] = 1'b1;
      bus.req_a[32*i +: 32] = a;
      bus.req_b[32*i +: 32] = b;
      bus.req_sig[14*i +: 14] = {op, 9'($urandom)};
   endtask
   task automatic wait_accept(int i, output int t);
      t = -1;
      for (int k = 0; k < 50 && t < 0; k++) begin
         @(negedge clk);
         if (bus.req_ready[i]) t = pcyc;
      end
      if (t < 0) chk("accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      bus.req_valid[i] = 1'b0;
   endtask
   task automatic wait_resp(output int t, output logic [63:0] d);
      t = -1;
      d = '0;
      for (int k = 0; k < 50 && t < 0; k++) begin
         @(negedge clk);
         if (bus.resp_valid) begin
            t = pcyc;
            d = {bus.resp_id, bus.resp_flags, bus.resp_result};
         end
      end
      if (t < 0) chk("resp_timeout", 0, 1);
   endtask
   task automatic run_op(string nm, int i, logic [4:0] op, logic [31:0] a, logic [31:0] b,
                         logic [33:0] er, int el);
      int t0, t1;
      logic [63:0] d;
      @(posedge clk);
      #1;
      set_req(i, op, a, b);
      wait_accept(i, t0);
      wait_resp(t1, d);
      chk({nm, "_lat"}, 64'(t1 - t0), 64'(el));
      chk({nm, "_resp"}, d, {IDW'(i), er});
   endtask
   logic [N-1:0] gr [4];
   logic [N-1:0] acc;
   int t0, t1, t2, ng;
   logic [63:0] d;
   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end
   initial begin
      bus.req_valid = '0;
      bus.req_a = '0;
      bus.req_b = '0;
      bus.req_sig = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", bus.busy, 0);
      chk("rst_resp", {bus.resp_valid, bus.resp_id, bus.resp_flags, bus.resp_result}, 0);
      chk("rst_alu", {alu_a, alu_b, alu_signals}, 0);
      run_op("add", 0, 5'd0, 5, 7, 34'd12, 2);
      run_op("mul", 1, 5'd2, 6, 7, 34'd42, 1 + ML);
      @(posedge clk);
      #1;
      set_req(0, 5'd5, 3, 3);
      set_req(1, 5'd5, 3, 3);
      ng = 0;
      for (int k = 0; k < 60 && ng < 4; k++) begin
         @(negedge clk);
         if (bus.req_ready != '0) begin
            gr[ng] = bus.req_ready;
            ng++;
            if (ng == 4) begin
               wait_resp(t0, d);
               chk("rr_flags", d, {IDW'(1), 2'b01, 32'h0});
            end
         end
      end
      bus.req_valid = '0;
      chk("rr_count", 64'(ng), 4);
      chk("rr_grant0", gr[0], 3'b001);
      chk("rr_grant1", gr[1], 3'b010);
      chk("rr_grant2", gr[2], 3'b001);
      chk("rr_grant3", gr[3], 3'b010);
      repeat (3) @(posedge clk);
      #1;
      set_req(0, 5'd0, 1, 2);
      wait_accept(0, t0);
      set_req(0, 5'd1, 10, 4);
      wait_accept(0, t1);
      wait_resp(t2, d);
      chk("b2b_accept", 64'(t1 - t0), 2);
      chk("b2b_lat", 64'(t2 - t1), 2);
      chk("b2b_resp", d, {IDW'(0), 34'd6});
      run_op("nop", 2, 5'd13, 3, 4, 34'd0, 2);
`ifdef ALU_DIV0_GUARD_EN
      run_op("div0", 0, 5'd3, 9, 0, {2'b00, 32'hFFFF_FFFF}, 2);
      run_op("mod0", 1, 5'd4, 9, 0, 34'd9, 2);
`else
      run_op("div0", 0, 5'd3, 9, 0, {2'b00, 32'hDEAD_BEEF}, 1 + ML);
      run_op("mod0", 1, 5'd4, 9, 0, {2'b00, 32'hBAD0_0BAD}, 1 + ML);
`endif
      run_op("div", 0, 5'd3, 100, 7, 34'd14, 1 + ML);
      @(posedge clk);
      #1;
      set_req(0, 5'd3, 100, 7);
      wait_accept(0, t0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      set_req(0, 5'd0, 1, 1);
      set_req(1, 5'd0, 2, 2);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_busy", bus.busy, 0);
      chk("midrst_out", {bus.resp_valid, bus.resp_id, bus.resp_flags, bus.resp_result, alu_a}, 0);
      chk("midrst_grant", bus.req_ready, 3'b001);
      wait_accept(0, t0);
      bus.req_valid = '0;
      repeat (10) @(posedge clk);
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         acc = bus.req_valid & bus.req_ready;
         @(posedge clk);
         #1;
         rst = ($urandom % 400) == 0;
         for (int i = 0; i < N; i++) begin
            if (acc[i]) bus.req_valid[i] = 1'b0;
            if (!bus.req_valid[i] && $urandom % 3 == 0) begin
               case ($urandom % 8)
                  0: set_req(i, 5'd0, $urandom % 64, $urandom % 64);
                  1: set_req(i, 5'd1, $urandom, $urandom);
                  2: set_req(i, 5'd2, $urandom % 1000, $urandom % 1000);
                  3: set_req(i, 5'd3, $urandom, ($urandom % 4 == 0) ? 0 : $urandom % 64);
                  4: set_req(i, 5'd4, $urandom, ($urandom % 4 == 0) ? 0 : $urandom % 64);
                  5: set_req(i, 5'd5, $urandom % 8, $urandom % 8);
                  6: set_req(i, 5'd13, $urandom, $urandom);
                  default: set_req(i, 5'(16 + $urandom % 16), $urandom, $urandom);
               endcase
            end
         end
      end
      rst = 1'b0;
      bus.req_valid = '0;
      repeat (20) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational ALU between NUM_REQ requesters, e.g. the execute stage and the CSR unit.
- Round-robin arbitration, one operation in flight at a time.
- Operands and control are registered into the ALU. Multi-cycle ops (mul/div/mod) are held stable for MULTI_LAT cycles before capture.
- Result and flags are returned to the winning requester as a tagged one-cycle pulse.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- MULTI_LAT, 4, EXEC cycles for opcodes 00010/00011/00100 (>=1).
- IDW, 3, width of the requester id (>= clog2(NUM_REQ)).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request.
- req_ready  out  NUM_REQ  one-hot accept, combinational, meaningful only in IDLE.
- req_a  in  32*NUM_REQ  operand a; slice i = [32*i+31:32*i].
- req_b  in  32*NUM_REQ  operand b.
- req_sig  in  14*NUM_REQ  ALU control word; [13:9] is the opcode, [2:0] are the mov/csr qualifiers.
- alu_a  out  32  to ALU a.
- alu_b  out  32  to ALU b.
- alu_signals  out  14  to ALU alusignals.
- alu_result  in  32  from ALU.
- alu_flags  in  2  from ALU; [1]=gt, [0]=eq.
- resp_valid  out  1  one-cycle completion pulse.
- resp_id  out  IDW  requester index of the completed op.
- resp_result  out  32  captured result.
- resp_flags  out  2  captured flags.
- busy  out  1  high when not IDLE.

Behaviour:
- Clocking: single clock domain. Reset is synchronous and active-high.
- Reset values:
  - state=IDLE, rr_ptr=0.
  - alu_a/alu_b/alu_signals=0.
  - resp_valid=0, resp_id=0, resp_result=0, resp_flags=0.
  - busy=0, req_ready=0.
- Reset mid-operation: the in-flight op is dropped and no resp_valid is issued for it.
- State IDLE:
  - Grant goes to the first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[i]=1 combinationally in that cycle. Handshake completes when valid&&ready.
  - On the edge: latch req_a/b/sig[i] into alu_a/alu_b/alu_signals, store grant id, set rr_ptr=(i+1) mod NUM_REQ.
  - Load cnt = MULTI_LAT-1 for opcodes 00010/00011/00100, else 0. Go to EXEC.
  - No valid requests: stay in IDLE, all outputs held.
- State EXEC:
  - alu_* held stable; req_ready=0.
  - cnt!=0: decrement.
  - cnt==0: on the edge capture alu_result/alu_flags into resp_result/resp_flags, resp_id=grant id, resp_valid=1 for exactly one cycle, go to IDLE.
- Back-to-back: in the cycle resp_valid=1 the block is in IDLE and may accept a new request.
  - Single-cycle ops: accept in cycle T gives resp_valid in T+2; maximum rate is one op per 2 cycles.
  - Multi-cycle ops: resp_valid in T+1+MULTI_LAT.
- Undefined ALU opcodes: 01101 (nop) and 10000..11111 take 1 EXEC cycle and return result 0, flags 00; the ALU output is ignored.
- Fairness: a requester that keeps req_valid high is granted within NUM_REQ grants.
- Request hold: req_* need not stay stable after the accepting edge. A request not accepted must hold valid (no drop-out requirement is enforced).
- resp_valid has no back-pressure; requesters must sink it.
- busy = (state!=IDLE).

Optional Feature:
- Macro: ALU_DIV0_GUARD_EN.
- Defined:
  - For opcode 00011 with b==0: the ALU output is ignored; return 32'hFFFF_FFFF, flags 00.
  - For opcode 00100 with b==0: return a, flags 00.
  - Both complete after 1 EXEC cycle instead of MULTI_LAT.
- Undefined: div/mod by zero goes through the ALU unchanged with MULTI_LAT cycles; the result is whatever the ALU produces.

Test Plan:
- Single add: req0 a=5, b=7, opcode 00000 at T → req_ready[0]=1 at T; resp_valid at T+2 with id=0, result=12, flags=00; busy high at T+1 only.
- Multi-cycle: req1 mul a=6, b=7, MULTI_LAT=4, accepted at T → alu_* stable T+1..T+4; resp_valid at T+5 with id=1, result=42.
- Round-robin: both requesters valid continuously with cmp (a=3, b=3) → grants alternate 0,1,0,1 starting from 0 after reset; each resp flags=01.
- Back-to-back: req0 issues a sub (a=10, b=4) immediately after the previous resp → new accept in the same cycle resp_valid=1; result 6 two cycles later.
- Reset mid-op: start div 100/7, assert reset at EXEC cycle 2 → no resp_valid; all outputs 0; next grant goes to req0 even if req1 is also valid.
- Nop/div0: opcode 01101 → result 0 after 2 cycles. With ALU_DIV0_GUARD_EN, div a=9, b=0 → result FFFF_FFFF at T+2; mod a=9, b=0 → result 9 at T+2.
